stopwatch_run_controller: RTL and testbench

//  Sequences the cascaded Counter_Half_Duplex digit chain of the stopwatch/timer.

---
 rtl/stopwatch_run_controller_pkg.sv | 17 +
 rtl/stopwatch_run_controller_tick_prescaler.sv | 31 +++
 rtl/stopwatch_run_controller.sv | 143 ++++++++++++++
 tb/tb_stopwatch_run_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_run_controller_pkg.sv
// Shared state encodings and sizing helper for the stopwatch run controller.
package stopwatch_run_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOADING = 3'd1,
      ST_RUNNING = 3'd2,
      ST_PAUSED  = 3'd3,
      ST_EXPIRED = 3'd4
   } state_t;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stopwatch_run_controller_tick_prescaler.sv
// Divides the system clock down to the base tick rate; holds its count while run is low.
module tick_prescaler
   import stopwatch_run_controller_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic zero,
   output logic tick
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int W   = cnt_w(DIV);

   logic [W-1:0] cnt;

   assign tick = run && (cnt == W'(DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (zero)
         cnt <= '0;
      else if (run)
         cnt <= tick ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/stopwatch_run_controller.sv
// Run/pause/load/expiry sequencer for the cascaded stopwatch digit chain.
module stopwatch_run_controller
   import stopwatch_run_controller_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int TICK_HZ     = 100,
   parameter int LOAD_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start_stop,
   input  logic clear,
   input  logic lap,
   input  logic load_req,
   input  logic mode_down,
   input  logic terminal,
   output logic cnt_enable,
   output logic cnt_up_down,
   output logic cnt_clear,
   output logic cnt_set,
   output logic load_drive,
   output logic lap_hold,
   output logic running,
   output logic alarm
);

   localparam int LW = cnt_w(LOAD_CYCLES);

   state_t        state;
   logic [LW-1:0] load_cnt;
   logic          tick;
   logic          presc_run;
   logic          presc_zero;

   // A pause edge must not advance the prescaler, so the fractional tick survives.
   assign presc_run  = (state == ST_RUNNING) && !start_stop && !clear;
   assign presc_zero = clear || (state == ST_IDLE) || (state == ST_LOADING) ||
                       (state == ST_EXPIRED);

   tick_prescaler #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_presc (
      .clk  (clk),
      .rst  (rst),
      .run  (presc_run),
      .zero (presc_zero),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         load_cnt    <= '0;
         cnt_enable  <= 1'b0;
         cnt_up_down <= 1'b1;
         cnt_clear   <= 1'b1;
         cnt_set     <= 1'b0;
         load_drive  <= 1'b0;
         lap_hold    <= 1'b0;
         running     <= 1'b0;
         alarm       <= 1'b0;
      end else begin
         cnt_enable <= 1'b0;
         cnt_clear  <= 1'b0;
         // Direction is only ever latched while idle.
         if (state == ST_IDLE)
            cnt_up_down <= ~mode_down;

         if (clear) begin
            state      <= ST_IDLE;
            cnt_clear  <= 1'b1;
            cnt_set    <= 1'b0;
            load_drive <= 1'b0;
            lap_hold   <= 1'b0;
            running    <= 1'b0;
            alarm      <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_stop) begin
                     state   <= ST_RUNNING;
                     running <= 1'b1;
                  end else if (load_req) begin
                     state      <= ST_LOADING;
                     load_cnt   <= '0;
                     cnt_set    <= 1'b1;
                     load_drive <= 1'b1;
                  end
               end
               ST_LOADING: begin
                  if (load_cnt == LW'(LOAD_CYCLES - 1)) begin
                     state      <= ST_IDLE;
                     cnt_set    <= 1'b0;
                     load_drive <= 1'b0;
                  end else begin
                     load_cnt <= load_cnt + 1'b1;
                  end
               end
               ST_RUNNING: begin
                  if (start_stop) begin
                     state   <= ST_PAUSED;
                     running <= 1'b0;
                  end else begin
                     if (lap)
                        lap_hold <= ~lap_hold;
                     // Terminal tick saturates instead of wrapping the chain.
                     if (tick) begin
                        if (terminal) begin
                           state   <= ST_EXPIRED;
                           running <= 1'b0;
                           alarm   <= 1'b1;
                        end else begin
                           cnt_enable <= 1'b1;
                        end
                     end
                  end
               end
               ST_PAUSED: begin
                  if (start_stop) begin
                     state   <= ST_RUNNING;
                     running <= 1'b1;
                  end else if (lap) begin
                     lap_hold <= 1'b0;
                  end
               end
               ST_EXPIRED: begin
                  if (start_stop) begin
                     state <= ST_IDLE;
                     alarm <= 1'b0;
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
                  alarm   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_run_controller.sv
// Directed bench for the stopwatch run controller at DIV=10, LOAD_CYCLES=2.
module tb_stopwatch_run_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_stop = 1'b0, clear = 1'b0, lap = 1'b0, load_req = 1'b0;
   logic mode_down = 1'b0, terminal = 1'b0;
   logic cnt_enable, cnt_up_down, cnt_clear, cnt_set, load_drive, lap_hold, running, alarm;

   int npass = 0;
   int ntotal = 0;

   stopwatch_run_controller #(
      .CLK_HZ      (1000),
      .TICK_HZ     (100),
      .LOAD_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_stop  (start_stop),
      .clear       (clear),
      .lap         (lap),
      .load_req    (load_req),
      .mode_down   (mode_down),
      .terminal    (terminal),
      .cnt_enable  (cnt_enable),
      .cnt_up_down (cnt_up_down),
      .cnt_clear   (cnt_clear),
      .cnt_set     (cnt_set),
      .load_drive  (load_drive),
      .lap_hold    (lap_hold),
      .running     (running),
      .alarm       (alarm)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " cnt_enable"}, int'(cnt_enable), 0);
      chk({tag, " cnt_up_down"}, int'(cnt_up_down), 1);
      chk({tag, " cnt_clear"}, int'(cnt_clear), 1);
      chk({tag, " cnt_set"}, int'(cnt_set), 0);
      chk({tag, " load_drive"}, int'(load_drive), 0);
      chk({tag, " lap_hold"}, int'(lap_hold), 0);
      chk({tag, " running"}, int'(running), 0);
      chk({tag, " alarm"}, int'(alarm), 0);
   endtask

   initial begin
      int n;
      // reset
      #2 rst = 1'b0;
      #1 chk_reset_vals("rst_async");
      step(); step();
      chk_reset_vals("rst_hold");
      rst = 1'b1;
      step();
      chk("rel cnt_clear", int'(cnt_clear), 0);
      chk("rel running", int'(running), 0);

      // start up mode: ticks at 10,20,30
      mode_down = 1'b0;
      start_stop = 1'b1; step(); start_stop = 1'b0;
      chk("start running", int'(running), 1);
      chk("start up_down", int'(cnt_up_down), 1);
      chk("start en", int'(cnt_enable), 0);
      for (int c = 1; c <= 30; c++) begin
         step();
         chk($sformatf("up en c%0d", c), int'(cnt_enable), int'(c % 10 == 0));
      end

      // lap twice while running; ticks keep coming
      for (int c = 31; c <= 40; c++) begin
         lap = (c == 31 || c == 35);
         step();
         lap = 1'b0;
         chk($sformatf("lap en c%0d", c), int'(cnt_enable), int'(c % 10 == 0));
         if (c == 31) chk("lap_hold on", int'(lap_hold), 1);
         if (c == 35) chk("lap_hold off", int'(lap_hold), 0);
      end

      // pause at prescaler=6, hold 50 cycles, resume -> tick 4 cycles later
      for (int c = 41; c <= 46; c++) step();
      start_stop = 1'b1; step(); start_stop = 1'b0;
      chk("pause running", int'(running), 0);
      n = 0;
      for (int c = 0; c < 50; c++) begin
         step();
         n += int'(cnt_enable);
      end
      chk("pause no ticks", n, 0);
      start_stop = 1'b1; step(); start_stop = 1'b0;
      chk("resume running", int'(running), 1);
      chk("resume en", int'(cnt_enable), 0);
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("resume en +%0d", c), int'(cnt_enable), int'(c == 4));
      end

      // priority: clear beats start_stop and lap
      lap = 1'b1; step(); lap = 1'b0;
      chk("pri lap_hold pre", int'(lap_hold), 1);
      clear = 1'b1; start_stop = 1'b1; lap = 1'b1;
      step();
      clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
      chk("pri cnt_clear", int'(cnt_clear), 1);
      chk("pri running", int'(running), 0);
      chk("pri lap_hold", int'(lap_hold), 0);
      step();
      chk("pri cnt_clear 1cyc", int'(cnt_clear), 0);
      n = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         n += int'(cnt_enable) + int'(running);
      end
      chk("pri idle quiet", n, 0);

      // load in down mode
      mode_down = 1'b1;
      step();
      chk("load up_down", int'(cnt_up_down), 0);
      load_req = 1'b1; step(); load_req = 1'b0;
      chk("load set c1", int'(cnt_set), 1);
      chk("load drive c1", int'(load_drive), 1);
      chk("load en c1", int'(cnt_enable), 0);
      start_stop = 1'b1; step(); start_stop = 1'b0;
      chk("load set c2", int'(cnt_set), 1);
      chk("load drive c2", int'(load_drive), 1);
      chk("load ignores start", int'(running), 0);
      step();
      chk("load set end", int'(cnt_set), 0);
      chk("load drive end", int'(load_drive), 0);
      chk("load running", int'(running), 0);

      // expiry: terminal before third tick
      start_stop = 1'b1; step(); start_stop = 1'b0;
      chk("dn running", int'(running), 1);
      chk("dn up_down", int'(cnt_up_down), 0);
      n = 0;
      for (int c = 1; c <= 35; c++) begin
         if (c == 25) terminal = 1'b1;
         step();
         n += int'(cnt_enable);
         if (c == 30) begin
            chk("exp alarm", int'(alarm), 1);
            chk("exp running", int'(running), 0);
         end
      end
      chk("exp enables", n, 2);
      chk("exp alarm hold", int'(alarm), 1);
      terminal = 1'b0;
      start_stop = 1'b1; step(); start_stop = 1'b0;
      chk("exp ack alarm", int'(alarm), 0);
      chk("exp ack running", int'(running), 0);
      chk("exp ack no clear", int'(cnt_clear), 0);
      mode_down = 1'b0;
      step();
      chk("exp idle up_down", int'(cnt_up_down), 1);

      // async reset mid-run
      mode_down = 1'b1;
      step();
      start_stop = 1'b1; step(); start_stop = 1'b0;
      lap = 1'b1; step(); lap = 1'b0;
      step(); step();
      chk("mid lap_hold", int'(lap_hold), 1);
      chk("mid up_down", int'(cnt_up_down), 0);
      rst = 1'b0;
      #1 chk_reset_vals("rst_mid");
      step();
      rst = 1'b1;
      mode_down = 1'b0;
      n = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         n += int'(cnt_enable) + int'(running);
      end
      chk("post rst idle", n, 0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
